// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator. It holds the
//                horizontal and vertical counters, which advance on pixel-clock
//                enable ticks. It decodes registered syncs and combinational
//                blanking and line/frame marker strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          pix_en,
    input  logic          restart,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_end,
    output logic          frame_end,
    output logic          vblank_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] c_H_MAX   = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_MAX   = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_V_LAST  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] c_HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] c_ONE     = CW'(1);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_hsync;
    logic          r_vsync;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic          w_hsync_nxt;
    logic          w_vsync_nxt;
    logic          w_tick;
    logic          w_at_hmax;

    // A qualified tick is a pixel enable that is not overridden by restart;
    // strobes are suppressed during reset and restart.
    assign w_tick    = pix_en && !restart && !clr;
    assign w_at_hmax = (r_x == c_H_MAX);

    // Next-state counters. Syncs are decoded from these, so the registered
    // syncs line up with the registered coordinates.
    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_hsync_nxt = ~HS_POL;
        w_vsync_nxt = ~VS_POL;
        if (restart) begin
            w_x_nxt = '0;
            w_y_nxt = '0;
        end else begin
            if (pix_en) begin
                if (w_at_hmax) begin
                    w_x_nxt = '0;
                    w_y_nxt = (r_y == c_V_MAX) ? '0 : (r_y + c_ONE);
                end else begin
                    w_x_nxt = r_x + c_ONE;
                end
            end
            if ((w_x_nxt >= c_HS_BEG) && (w_x_nxt < c_HS_END)) begin
                w_hsync_nxt = HS_POL;
            end
            if ((w_y_nxt >= c_VS_BEG) && (w_y_nxt < c_VS_END)) begin
                w_vsync_nxt = VS_POL;
            end
        end
    end

    // Counter and sync registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hsync <= w_hsync_nxt;
            r_vsync <= w_vsync_nxt;
        end
    end

    assign x            = r_x;
    assign y            = r_y;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign video_on     = (r_x < c_H_ACT) && (r_y < c_V_ACT);
    assign line_end     = w_tick && w_at_hmax;
    assign frame_end    = w_tick && w_at_hmax && (r_y == c_V_MAX);
    assign vblank_start = w_tick && w_at_hmax && (r_y == c_V_LAST);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed bench for vga_timing_gen. It uses one default-timing
//                instance for line, reset and restart behaviour and one small
//                override instance for full-frame and strobed-enable behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic        clk;
    logic        clr;
    logic        d_pix_en, d_restart;
    logic        s_pix_en, s_restart;
    logic        d_hsync, d_vsync, d_video_on, d_line_end, d_frame_end, d_vblank_start;
    logic        s_hsync, s_vsync, s_video_on, s_line_end, s_frame_end, s_vblank_start;
    logic [10:0] d_x, d_y, s_x, s_y;

    int n_vec;
    int n_err;

    vga_timing_gen u_dut (
        .clk(clk), .clr(clr), .pix_en(d_pix_en), .restart(d_restart),
        .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
        .x(d_x), .y(d_y), .line_end(d_line_end), .frame_end(d_frame_end),
        .vblank_start(d_vblank_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
    ) u_small (
        .clk(clk), .clr(clr), .pix_en(s_pix_en), .restart(s_restart),
        .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
        .x(s_x), .y(s_y), .line_end(s_line_end), .frame_end(s_frame_end),
        .vblank_start(s_vblank_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the vector and reports a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the small instance for nclk clocks with pix_en every period-th clk,
    // checking every cycle against a tick-indexed raster position.
    task automatic run_small(input int period, input int nclk);
        int t, ex, ey, last_fe, fe_cnt;
        t = 0; last_fe = -1; fe_cnt = 0;
        for (int c = 0; c < nclk; c++) begin
            s_pix_en = ((c % period) == period - 1);
            #1;
            ex = t % 12;
            ey = (t / 12) % 7;
            chk("s_x", 32'(s_x), ex);
            chk("s_y", 32'(s_y), ey);
            chk("s_hsync", 32'(s_hsync), (ex == 9 || ex == 10) ? 1 : 0);
            chk("s_vsync", 32'(s_vsync), (ey == 5) ? 1 : 0);
            chk("s_video_on", 32'(s_video_on), (ex < 8 && ey < 4) ? 1 : 0);
            chk("s_line_end", 32'(s_line_end), (s_pix_en && ex == 11) ? 1 : 0);
            chk("s_frame_end", 32'(s_frame_end), (s_pix_en && ex == 11 && ey == 6) ? 1 : 0);
            chk("s_vblank_start", 32'(s_vblank_start), (s_pix_en && ex == 11 && ey == 3) ? 1 : 0);
            if (s_frame_end) begin
                if (last_fe >= 0) chk("s_frame_period", t - last_fe, 84);
                last_fe = t;
                fe_cnt++;
            end
            if (s_pix_en) t++;
            step();
        end
        chk("s_frame_end_count", fe_cnt, 2);
    endtask

    initial begin
        int hs_low, le_cnt;
        n_vec = 0; n_err = 0;
        clr = 1'b1;
        d_pix_en = 1'b0; d_restart = 1'b0;
        s_pix_en = 1'b0; s_restart = 1'b0;
        repeat (3) step();
        chk("rst_x", 32'(d_x), 0);
        chk("rst_y", 32'(d_y), 0);
        chk("rst_hsync", 32'(d_hsync), 1);
        chk("rst_vsync", 32'(d_vsync), 1);
        chk("rst_video_on", 32'(d_video_on), 1);

        // Count a little, then clear mid-count for 3 clocks.
        clr = 1'b0; d_pix_en = 1'b1;
        repeat (37) step();
        chk("pre_clr_x", 32'(d_x), 37);
        clr = 1'b1;
        #1;
        chk("async_clr_x", 32'(d_x), 0);
        repeat (3) step();
        chk("clr_x", 32'(d_x), 0);
        chk("clr_y", 32'(d_y), 0);
        chk("clr_hsync", 32'(d_hsync), 1);
        chk("clr_vsync", 32'(d_vsync), 1);
        chk("clr_video_on", 32'(d_video_on), 1);
        chk("clr_line_end", 32'(d_line_end), 0);
        chk("clr_frame_end", 32'(d_frame_end), 0);
        chk("clr_vblank_start", 32'(d_vblank_start), 0);
        clr = 1'b0;
        #1;

        // One full line with pix_en tied high.
        hs_low = 0; le_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            chk("line_x", 32'(d_x), i);
            chk("line_y", 32'(d_y), 0);
            chk("line_hsync", 32'(d_hsync), (i >= 656 && i < 752) ? 0 : 1);
            chk("line_video_on", 32'(d_video_on), (i < 640) ? 1 : 0);
            chk("line_line_end", 32'(d_line_end), (i == 799) ? 1 : 0);
            if (!d_hsync) hs_low++;
            if (d_line_end) le_cnt++;
            step();
        end
        chk("hsync_low_count", hs_low, 96);
        chk("line_end_count", le_cnt, 1);
        chk("wrap_x", 32'(d_x), 0);
        chk("wrap_y", 32'(d_y), 1);
        chk("wrap_vsync", 32'(d_vsync), 1);

        // pix_en low holds every register.
        d_pix_en = 1'b0;
        repeat (3) step();
        chk("hold_x", 32'(d_x), 0);
        chk("hold_y", 32'(d_y), 1);

        // Restart mid-line with pix_en low.
        d_pix_en = 1'b1;
        repeat (300) step();
        chk("pre_rst_x", 32'(d_x), 300);
        d_pix_en = 1'b0; d_restart = 1'b1;
        #1;
        chk("restart_line_end", 32'(d_line_end), 0);
        step();
        d_restart = 1'b0;
        #1;
        chk("restart_x", 32'(d_x), 0);
        chk("restart_y", 32'(d_y), 0);
        chk("restart_hsync", 32'(d_hsync), 1);
        chk("restart_vsync", 32'(d_vsync), 1);

        // Restart at the end of a line must suppress the strobe and not wrap y.
        d_pix_en = 1'b1;
        repeat (799) step();
        chk("eol_x", 32'(d_x), 799);
        chk("eol_line_end", 32'(d_line_end), 1);
        d_restart = 1'b1;
        #1;
        chk("eol_restart_line_end", 32'(d_line_end), 0);
        step();
        d_restart = 1'b0;
        #1;
        chk("eol_restart_x", 32'(d_x), 0);
        chk("eol_restart_y", 32'(d_y), 0);

        // Small-override instance: start from a clean restart.
        s_restart = 1'b1; s_pix_en = 1'b0;
        step();
        s_restart = 1'b0;
        #1;
        chk("s_restart_hsync", 32'(s_hsync), 0);
        chk("s_restart_vsync", 32'(s_vsync), 0);
        run_small(1, 170);

        s_restart = 1'b1; s_pix_en = 1'b0;
        step();
        s_restart = 1'b0;
        run_small(3, 510);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
